// File: rtl/resource_alloc_pkg.sv
// rtl/resource_alloc_pkg.sv - port state enum, wrap-aware age compare and width helpers for the unit allocator
package resource_alloc_pkg;

    typedef enum logic {ALLOC_IDLE = 1'b0, ALLOC_OWN = 1'b1} alloc_state_e;

    localparam int ALLOC_ID_MAX_W = 32;
    typedef logic [ALLOC_ID_MAX_W-1:0] alloc_id_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Callers MSB-align narrower ids into alloc_id_t so the sign of the difference is the wrap-aware age.
    function automatic logic is_older(input alloc_id_t a, input alloc_id_t b);
        alloc_id_t diff;
        diff = a - b;
        return diff[ALLOC_ID_MAX_W-1];
    endfunction

endpackage

// File: rtl/oldest_first_unit_allocator_if.sv
// rtl/oldest_first_unit_allocator_if.sv - SIC-side request/grant bundle; ALLOC_PERF_COUNTERS_EN adds counter outputs
interface oldest_first_unit_allocator_if #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_UNITS = 4,
    parameter int ID_WIDTH  = 16
);
    import resource_alloc_pkg::*;

    localparam int UW = idx_w(NUM_UNITS);
    localparam int CW = cnt_w(NUM_UNITS);

    logic [NUM_PORTS-1:0]               req;
    logic [NUM_PORTS-1:0][ID_WIDTH-1:0] issue_id;
    logic [NUM_PORTS-1:0]               rel;    // release pulse; "release" is a reserved word
    logic                               flush;
    logic [NUM_PORTS-1:0]               grant;
    logic [NUM_PORTS-1:0][UW-1:0]       unit_idx;
    logic [CW-1:0]                      free_count;
`ifdef ALLOC_PERF_COUNTERS_EN
    logic [31:0]                        grant_total;
    logic [31:0]                        stall_cycles;

    modport master (output req, issue_id, rel, flush,
                    input  grant, unit_idx, free_count, grant_total, stall_cycles);
    modport slave  (input  req, issue_id, rel, flush,
                    output grant, unit_idx, free_count, grant_total, stall_cycles);
`else
    modport master (output req, issue_id, rel, flush,
                    input  grant, unit_idx, free_count);
    modport slave  (input  req, issue_id, rel, flush,
                    output grant, unit_idx, free_count);
`endif
endinterface

// File: rtl/oldest_first_unit_allocator_age_priority_picker.sv
// rtl/oldest_first_unit_allocator_age_priority_picker.sv - combinational oldest-first ranking of candidate ports
module age_priority_picker
    import resource_alloc_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ID_WIDTH  = 16,
    localparam int RW = idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0]               cand,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] issue_id,
    output logic [NUM_PORTS-1:0][RW-1:0]       rank
);

    alloc_id_t                   al_id [NUM_PORTS];
    logic [NUM_PORTS-1:0][RW-1:0] beaten;
    logic                         o_ji;
    logic                         o_ij;

    // A second pass re-ranks by beaten-count so a non-transitive wrap cycle still yields unique ranks.
    always_comb begin
        o_ji = 1'b0;
        o_ij = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++)
            al_id[i] = alloc_id_t'(issue_id[i]) << (ALLOC_ID_MAX_W - ID_WIDTH);
        for (int i = 0; i < NUM_PORTS; i++) begin
            beaten[i] = '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                o_ji = is_older(al_id[j], al_id[i]);
                o_ij = is_older(al_id[i], al_id[j]);
                if (j != i && cand[j] && ((o_ji && !o_ij) || (o_ji == o_ij && j < i)))
                    beaten[i] = beaten[i] + RW'(1);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            rank[i] = '0;
            for (int j = 0; j < NUM_PORTS; j++)
                if (j != i && cand[j] && (beaten[j] < beaten[i] || (beaten[j] == beaten[i] && j < i)))
                    rank[i] = rank[i] + RW'(1);
        end
    end

endmodule

// File: rtl/oldest_first_unit_allocator.sv
// rtl/oldest_first_unit_allocator.sv - oldest-issue-first allocator of shared units to SIC ports
// Optional ALLOC_PERF_COUNTERS_EN adds wrapping grant_total / stall_cycles counters.
module oldest_first_unit_allocator
    import resource_alloc_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int NUM_UNITS = 4,
    parameter int ID_WIDTH  = 16
) (
    input logic                          clk,
    input logic                          rst_n,
    oldest_first_unit_allocator_if.slave bus
);

    localparam int UW = idx_w(NUM_UNITS);
    localparam int CW = cnt_w(NUM_UNITS);
    localparam int RW = idx_w(NUM_PORTS);

    alloc_state_e                 state_q [NUM_PORTS];
    alloc_state_e                 state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][UW-1:0] unit_q, unit_d;
    logic [CW-1:0]                free_count_q, free_count_d;
    logic [NUM_UNITS-1:0]         owned;
    logic [NUM_PORTS-1:0]         cand, granted_now;
    logic [NUM_PORTS-1:0][RW-1:0] rank;
    int                           seen, n_own, n_grant;
    logic                         dup_unit;

    always_comb begin
        owned = '0;
        for (int u = 0; u < NUM_UNITS; u++)
            for (int p = 0; p < NUM_PORTS; p++)
                if (state_q[p] == ALLOC_OWN && unit_q[p] == UW'(u)) owned[u] = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++)
            cand[p] = !bus.flush && state_q[p] == ALLOC_IDLE && bus.req[p] && !bus.rel[p];
    end

    age_priority_picker #(.NUM_PORTS(NUM_PORTS), .ID_WIDTH(ID_WIDTH)) u_picker (
        .cand     (cand),
        .issue_id (bus.issue_id),
        .rank     (rank)
    );

    // Rank k takes the k-th lowest free unit; units freed this cycle are still owned here.
    always_comb begin
        state_d      = state_q;
        unit_d       = unit_q;
        granted_now  = '0;
        seen         = 0;
        n_own        = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            seen = 0;
            if (cand[p]) begin
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (!owned[u]) begin
                        if (seen == int'(rank[p])) begin
                            granted_now[p] = 1'b1;
                            unit_d[p]      = UW'(u);
                        end
                        seen = seen + 1;
                    end
                end
            end
            if (bus.flush)
                state_d[p] = ALLOC_IDLE;
            else if (state_q[p] == ALLOC_OWN) begin
                if (bus.rel[p] || !bus.req[p]) state_d[p] = ALLOC_IDLE;
            end else if (granted_now[p])
                state_d[p] = ALLOC_OWN;
            if (state_d[p] == ALLOC_OWN) n_own = n_own + 1;
        end
        free_count_d = CW'(NUM_UNITS - n_own);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= ALLOC_IDLE;
            unit_q       <= '0;
            free_count_q <= CW'(NUM_UNITS);
        end else begin
            state_q      <= state_d;
            unit_q       <= unit_d;
            free_count_q <= free_count_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) bus.grant[p] = (state_q[p] == ALLOC_OWN);
    end
    assign bus.unit_idx   = unit_q;
    assign bus.free_count = free_count_q;

`ifdef ALLOC_PERF_COUNTERS_EN
    logic [31:0] grant_total_q, grant_total_d, stall_cycles_q, stall_cycles_d;

    always_comb begin
        grant_total_d = grant_total_q;
        for (int p = 0; p < NUM_PORTS; p++)
            if (granted_now[p]) grant_total_d = grant_total_d + 32'd1;
        stall_cycles_d = stall_cycles_q + {31'd0, |(cand & ~granted_now)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_total_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            grant_total_q  <= grant_total_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.grant_total  = grant_total_q;
    assign bus.stall_cycles = stall_cycles_q;
`endif

    always_comb begin
        n_grant  = 0;
        dup_unit = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (state_q[p] == ALLOC_OWN) n_grant = n_grant + 1;
            for (int q = p + 1; q < NUM_PORTS; q++)
                if (state_q[p] == ALLOC_OWN && state_q[q] == ALLOC_OWN && unit_q[p] == unit_q[q])
                    dup_unit = 1'b1;
        end
    end

    a_count_conserved: assert property (@(posedge clk) disable iff (!rst_n)
        int'(free_count_q) + n_grant == NUM_UNITS);
    a_unit_unique: assert property (@(posedge clk) disable iff (!rst_n) !dup_unit);

endmodule

// File: tb/tb_oldest_first_unit_allocator.sv
// tb/tb_oldest_first_unit_allocator.sv - vector table with scoreboard queue plus hand-written corner sequences
module tb_oldest_first_unit_allocator;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    oldest_first_unit_allocator_if #(.NUM_PORTS(2), .NUM_UNITS(4), .ID_WIDTH(16)) bus_a ();
    oldest_first_unit_allocator_if #(.NUM_PORTS(2), .NUM_UNITS(1), .ID_WIDTH(16)) bus_c ();

    oldest_first_unit_allocator #(.NUM_PORTS(2), .NUM_UNITS(4), .ID_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    oldest_first_unit_allocator #(.NUM_PORTS(2), .NUM_UNITS(1), .ID_WIDTH(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c));

    typedef struct {
        int          dut;
        logic [1:0]  req;
        logic [15:0] id0;
        logic [15:0] id1;
        logic [1:0]  rel;
        logic        flush;
        logic [1:0]  grant;
        logic [1:0]  u0;
        logic [1:0]  u1;
        logic [2:0]  free;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(int dut, logic [1:0] req, logic [15:0] id0, logic [15:0] id1,
                                logic [1:0] rel, logic flush, logic [1:0] grant,
                                logic [1:0] u0, logic [1:0] u1, logic [2:0] free);
        vec_t v;
        v.dut = dut; v.req = req; v.id0 = id0; v.id1 = id1; v.rel = rel; v.flush = flush;
        v.grant = grant; v.u0 = u0; v.u1 = u1; v.free = free;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        bus_a.req = '0; bus_a.rel = '0; bus_a.flush = 1'b0; bus_a.issue_id = '0;
        bus_c.req = '0; bus_c.rel = '0; bus_c.flush = 1'b0; bus_c.issue_id = '0;
    endtask

    task automatic drive(input vec_t v);
        idle_all();
        if (v.dut == 0) begin
            bus_a.req = v.req; bus_a.rel = v.rel; bus_a.flush = v.flush;
            bus_a.issue_id[0] = v.id0; bus_a.issue_id[1] = v.id1;
        end else begin
            bus_c.req = v.req; bus_c.rel = v.rel; bus_c.flush = v.flush;
            bus_c.issue_id[0] = v.id0; bus_c.issue_id[1] = v.id1;
        end
    endtask

    task automatic compare_rec(input vec_t e, input string tag);
        logic [1:0] g, u0, u1;
        logic [2:0] fc;
        if (e.dut == 0) begin
            g = bus_a.grant; u0 = bus_a.unit_idx[0]; u1 = bus_a.unit_idx[1]; fc = bus_a.free_count;
        end else begin
            g = bus_c.grant; u0 = {1'b0, bus_c.unit_idx[0]}; u1 = {1'b0, bus_c.unit_idx[1]};
            fc = {2'b00, bus_c.free_count};
        end
        check({tag, "_grant"}, 32'(g), 32'(e.grant));
        check({tag, "_free"}, 32'(fc), 32'(e.free));
        if (e.grant[0]) check({tag, "_unit0"}, 32'(u0), 32'(e.u0));
        if (e.grant[1]) check({tag, "_unit1"}, 32'(u1), 32'(e.u1));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   n;

        // dut 0: 2 ports, 4 units
        vecs.push_back(mk(0, 2'b01, 16'd5,    16'd0,    2'b00, 0, 2'b01, 2'd0, 2'd0, 3'd3));
        vecs.push_back(mk(0, 2'b00, 16'd5,    16'd0,    2'b01, 0, 2'b00, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk(0, 2'b11, 16'd10,   16'd7,    2'b00, 0, 2'b11, 2'd1, 2'd0, 3'd2));
        vecs.push_back(mk(0, 2'b11, 16'd10,   16'd7,    2'b10, 0, 2'b01, 2'd1, 2'd0, 3'd3));
        vecs.push_back(mk(0, 2'b11, 16'd10,   16'd7,    2'b00, 0, 2'b11, 2'd1, 2'd0, 3'd2));
        vecs.push_back(mk(0, 2'b10, 16'd10,   16'd7,    2'b00, 0, 2'b10, 2'd0, 2'd0, 3'd3));
        vecs.push_back(mk(0, 2'b00, 16'd10,   16'd7,    2'b01, 0, 2'b00, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk(0, 2'b01, 16'd5,    16'd0,    2'b01, 0, 2'b00, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk(0, 2'b01, 16'd5,    16'd0,    2'b00, 0, 2'b01, 2'd0, 2'd0, 3'd3));
        vecs.push_back(mk(0, 2'b11, 16'd5,    16'd1,    2'b00, 0, 2'b11, 2'd0, 2'd1, 3'd2));
        vecs.push_back(mk(0, 2'b11, 16'd5,    16'd1,    2'b00, 1, 2'b00, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk(0, 2'b11, 16'd5,    16'd1,    2'b00, 0, 2'b11, 2'd1, 2'd0, 3'd2));
        vecs.push_back(mk(0, 2'b00, 16'd5,    16'd1,    2'b00, 0, 2'b00, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk(0, 2'b11, 16'h1234, 16'h1234, 2'b00, 0, 2'b11, 2'd0, 2'd1, 3'd2));
        vecs.push_back(mk(0, 2'b00, 16'h1234, 16'h1234, 2'b00, 0, 2'b00, 2'd0, 2'd0, 3'd4));
        vecs.push_back(mk(0, 2'b11, 16'hFFFE, 16'h0001, 2'b00, 0, 2'b11, 2'd0, 2'd1, 3'd2));
        vecs.push_back(mk(0, 2'b00, 16'hFFFE, 16'h0001, 2'b00, 0, 2'b00, 2'd0, 2'd0, 3'd4));
        // dut 1: 2 ports, 1 unit
        vecs.push_back(mk(1, 2'b11, 16'd10,   16'd7,    2'b00, 0, 2'b10, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk(1, 2'b11, 16'd10,   16'd7,    2'b00, 0, 2'b10, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk(1, 2'b11, 16'd10,   16'd7,    2'b10, 0, 2'b00, 2'd0, 2'd0, 3'd1));
        vecs.push_back(mk(1, 2'b01, 16'd10,   16'd7,    2'b00, 0, 2'b01, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk(1, 2'b00, 16'd10,   16'd7,    2'b00, 0, 2'b00, 2'd0, 2'd0, 3'd1));
        vecs.push_back(mk(1, 2'b11, 16'hFFFE, 16'h0001, 2'b00, 0, 2'b01, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk(1, 2'b00, 16'hFFFE, 16'h0001, 2'b00, 0, 2'b00, 2'd0, 2'd0, 3'd1));
        vecs.push_back(mk(1, 2'b11, 16'h0001, 16'hFFFE, 2'b00, 0, 2'b10, 2'd0, 2'd0, 3'd0));
        vecs.push_back(mk(1, 2'b11, 16'h0001, 16'hFFFE, 2'b00, 1, 2'b00, 2'd0, 2'd0, 3'd1));
        vecs.push_back(mk(1, 2'b00, 16'h0001, 16'hFFFE, 2'b00, 0, 2'b00, 2'd0, 2'd0, 3'd1));

        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        check("reset_grant_a", 32'(bus_a.grant), 32'd0);
        check("reset_unit_a", 32'({bus_a.unit_idx[1], bus_a.unit_idx[0]}), 32'd0);
        check("reset_free_a", 32'(bus_a.free_count), 32'd4);
        check("reset_free_c", 32'(bus_c.free_count), 32'd1);
`ifdef ALLOC_PERF_COUNTERS_EN
        check("reset_gtotal_a", bus_a.grant_total, 32'd0);
        check("reset_stall_a", bus_a.stall_cycles, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compare_rec(e, $sformatf("v%0d", i));
        end
        idle_all();

`ifdef ALLOC_PERF_COUNTERS_EN
        check("perf_gtotal_a", bus_a.grant_total, 32'd12);
        check("perf_stall_a", bus_a.stall_cycles, 32'd0);
        check("perf_gtotal_c", bus_c.grant_total, 32'd4);
        check("perf_stall_c", bus_c.stall_cycles, 32'd5);
`endif

        // Single unit held by port0 while port1 waits; freed unit reaches port1 two edges after release
        bus_c.issue_id[0] = 16'd100; bus_c.issue_id[1] = 16'd50;
        bus_c.req = 2'b01;
        @(posedge clk); #1;
        check("fp_own0", 32'(bus_c.grant), 32'd1);
        bus_c.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("fp_wait%0d", k), 32'(bus_c.grant), 32'b01);
        end
        check("fp_free0", 32'(bus_c.free_count), 32'd0);
        bus_c.rel = 2'b01; bus_c.req = 2'b10;
        @(posedge clk); #1;
        bus_c.rel = 2'b00;
        check("fp_rel_edge", 32'(bus_c.grant), 32'd0);
        @(posedge clk); #1;
        check("fp_t2_grant", 32'(bus_c.grant), 32'b10);
        check("fp_t2_unit", 32'(bus_c.unit_idx[1]), 32'd0);
        bus_c.req = 2'b00;

        // Flush with one owner while port1 newly requests in the flush cycle
        bus_a.issue_id[0] = 16'd3; bus_a.issue_id[1] = 16'd2;
        bus_a.req = 2'b01;
        @(posedge clk); #1;
        check("fl_own0", 32'(bus_a.grant), 32'b01);
        bus_a.req = 2'b11; bus_a.flush = 1'b1;
        @(posedge clk); #1;
        bus_a.flush = 1'b0;
        check("fl_grant", 32'(bus_a.grant), 32'd0);
        check("fl_free", 32'(bus_a.free_count), 32'd4);
        n = 0;
        while (bus_a.grant[1] !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("fl_latency", 32'(n), 32'd1);
        check("fl_regrant", 32'(bus_a.grant), 32'b11);
        bus_a.req = 2'b00;
        @(posedge clk); #1;

        // Asynchronous reset in mid-cycle
        bus_a.req = 2'b01;
        @(posedge clk); #1;
        check("ar_own", 32'(bus_a.grant), 32'b01);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_grant", 32'(bus_a.grant), 32'd0);
        check("ar_free", 32'(bus_a.free_count), 32'd4);
        bus_a.req = 2'b00;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar_after", 32'(bus_a.grant), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/oldest_first_unit_allocator.md
Name: oldest_first_unit_allocator

Overview:
- Shares a pool of NUM_UNITS identical execution units, such as ALUs, between NUM_PORTS single-instruction controllers.
- Arbitration is oldest-issue-id-first with a wrap-aware compare. A granted port holds its unit until it releases it.
- Sits between the SIC array and the functional-unit pool. It outputs per-port grant and unit index; the pool uses these to steer operands and results.
- A global flush (rollback) revokes every ownership.

Parameters:
- NUM_PORTS, 2, number of requesting SICs.
- NUM_UNITS, 4, number of shareable units.
- ID_WIDTH, 16, issue-id width; ids wrap modulo 2^ID_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req[NUM_PORTS]  input  1 each  port requests a unit; level, held until granted.
- issue_id[NUM_PORTS]  input  ID_WIDTH each  age of requester; stable while req is high.
- release[NUM_PORTS]  input  1 each  pulse; frees the unit owned by this port.
- flush  input  1  rollback; revokes all grants.
- grant[NUM_PORTS]  output  1 each  registered; high while the port owns a unit.
- unit_idx[NUM_PORTS]  output  $clog2(NUM_UNITS) each  unit owned; valid only when grant is high.
- free_count  output  $clog2(NUM_UNITS+1)  registered count of unowned units.

Behaviour:
- Reset values: all grant=0, all unit_idx=0, free_count=NUM_UNITS, all unit owner tables cleared.
- Per-port FSM, states IDLE and OWN:
  - IDLE to OWN when the port is selected in arbitration.
  - OWN to IDLE on release, on req deasserting (implicit release), or on flush.
- Latency:
  - req sampled at edge t; grant visible after edge t+1 at the earliest (one-cycle registered grant).
  - Release at edge t: grant low after t+1. The freed unit is allocatable in arbitration evaluated during cycle t+1 (granted at t+2). No same-cycle reuse.
- Age compare: a is older than b iff MSB of (a - b) mod 2^ID_WIDTH is 1. Equal ids tie-break to the lower port index.
- Arbitration each cycle:
  - Candidates are ports in IDLE with req=1 and release=0.
  - Candidates are ranked oldest-first. The k-th oldest candidate receives the k-th lowest-indexed free unit while free units remain.
  - Remaining candidates keep waiting with grant=0.
- Release and req high in the same cycle from one port: release wins, and the request is ignored that cycle.
- Release while IDLE: ignored, no state change.
- Full pool (free_count=0): no grants; requests persist.
- Flush:
  - Takes priority over everything else.
  - At the next edge, all grant=0 and all owners are cleared; free_count becomes NUM_UNITS.
  - Requests present in the flush cycle are not arbitrated.
- Invariants (asserted in simulation):
  - A unit has at most one owner.
  - free_count + number of grants == NUM_UNITS.
  - unit_idx is unique across granted ports.
- Asynchronous reset mid-operation clears state immediately, regardless of clk.

Optional Feature:
- Macro ALLOC_PERF_COUNTERS_EN.
- When defined, two extra outputs are added:
  - grant_total (32 bit): increments once per new grant.
  - stall_cycles (32 bit): increments each cycle in which at least one candidate is denied for lack of a free unit.
- Both counters wrap, reset to 0, and are not cleared by flush.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Shared package resource_alloc_pkg holds:
  - the port state enum (ALLOC_IDLE, ALLOC_OWN);
  - function is_older(a, b) parameterised by ID_WIDTH via a typedef;
  - localparam helpers for index widths.
- One sub-module, age_priority_picker, is combinational. It takes a candidate mask plus ids and produces a per-port rank. The top level holds all sequential state.

Test Plan:
- Single request: port0 req, id=5 -> grant0=1 and unit_idx0=0 one cycle later; free_count 4->3. Release -> grant0=0 next cycle; free_count=4.
- Age order with NUM_UNITS overridden to 1: port0 id=10 and port1 id=7 request together -> port1 granted first. After port1 releases, port0 is granted exactly two cycles after the release edge.
- Wrap-around: port0 id=0xFFFE, port1 id=0x0001, one free unit -> port0 granted (older across the wrap).
- Full pool: with 4 units owned, a new req stays ungranted. On a release, the waiting port gets the freed unit_idx at t+2.
- Flush with two grants active: flush=1 -> both grants 0 next cycle, free_count=4; a req asserted during the flush cycle is granted no earlier than two cycles after flush.
- With ALLOC_PERF_COUNTERS_EN: 3 grants plus 2 denied cycles -> grant_total=3 and stall_cycles=2; both unchanged by flush.
